// File: rtl/pipelined_mux_tree.sv
// pipelined_mux_tree
//   N_IN:1 multiplexer built as a tree of RADIX:1 levels. Each level has one
//   register stage, and the levels are joined by a valid/ready handshake.
//   Level i is steered by select digit i, taken LSB-first.
//   Latency is LEVELS cycles. Throughput is one word per cycle.
//
// Optional feature macro: MUX_SEL_ERR_EN
//   When defined, the block adds the sel_err output. It flags words whose
//   select was >= N_IN.
//
// Ports
//   clk        in   1            rising-edge clock
//   rst_n      in   1            asynchronous active-low reset
//   in         in   N_IN*WIDTH   flattened inputs, input k = in[k*WIDTH +: WIDTH]
//   sel        in   SEL_W        input index, sampled with in_valid
//   in_valid   in   1            in/sel valid this cycle
//   in_ready   out  1            block accepts in/sel this cycle (combinational)
//   out        out  WIDTH        selected data, registered
//   out_sel    out  SEL_W        sel value that produced out, registered
//   out_valid  out  1            out/out_sel valid
//   out_ready  in   1            downstream accepts out this cycle
//   sel_err    out  1            (MUX_SEL_ERR_EN only) word had sel >= N_IN
module pipelined_mux_tree #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned N_IN  = 32,
    parameter int unsigned RADIX = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN*WIDTH-1:0]   in,
    input  logic [$clog2(N_IN)-1:0] sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out,
    output logic [$clog2(N_IN)-1:0] out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MUX_SEL_ERR_EN
    ,
    output logic                    sel_err
`endif
);

    localparam int unsigned SEL_W  = $clog2(N_IN);
    localparam int unsigned SELX_W = SEL_W + 1;
    localparam int unsigned DIG_W  = $clog2(RADIX);
    localparam int unsigned LEVELS = (SEL_W + DIG_W - 1) / DIG_W;
    localparam int unsigned EXT_W  = LEVELS * DIG_W;
    // Leaf count rounded up to a full tree; leaves at index >= N_IN read as 0.
    localparam int unsigned NPAD   = 1 << EXT_W;

    // ready[i]: stage i may load this cycle; ready[LEVELS] is the downstream.
    logic [LEVELS:0] ready;

    assign ready[LEVELS] = out_ready;
    // Reset holds off new input even though the emptied stages look ready.
    assign in_ready      = rst_n & ready[0];

    for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
        localparam int unsigned N_SRC = NPAD >> (i * DIG_W);
        localparam int unsigned N_OUT = N_SRC / RADIX;
        localparam int unsigned SRC_W = N_SRC * WIDTH;
        localparam int unsigned OUT_W = N_OUT * WIDTH;

        logic [SRC_W-1:0] src_data;
        logic [SEL_W-1:0] src_sel;
        logic             src_valid;
        logic [DIG_W-1:0] digit;
        logic [OUT_W-1:0] data_d;

        logic             valid_q;
        logic [OUT_W-1:0] data_q;
        logic [SEL_W-1:0] sel_q;

        // Source of this level: the primary inputs, or the previous stage.
        if (i == 0) begin : g_src
            assign src_data  = SRC_W'(in);
            assign src_sel   = sel;
            assign src_valid = in_valid;
        end else begin : g_src
            assign src_data  = g_lvl[i-1].data_q;
            assign src_sel   = g_lvl[i-1].sel_q;
            assign src_valid = g_lvl[i-1].valid_q;
        end

        // Digit i of the tag. The top digit is zero-extended past SEL_W.
        assign digit = DIG_W'(EXT_W'(src_sel) >> (i * DIG_W));

        // Group j holds the RADIX consecutive sources j*RADIX .. j*RADIX+RADIX-1.
        always_comb begin
            data_d = '0;
            for (int unsigned j = 0; j < N_OUT; j++) begin
                data_d[j*WIDTH +: WIDTH] =
                    src_data[(j * RADIX + 32'(digit)) * WIDTH +: WIDTH];
            end
        end

        // Stage register. Data and tag load only on a real transfer, so a
        // stalled word stays put.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                sel_q   <= '0;
            end else if (ready[i]) begin
                valid_q <= src_valid;
                if (src_valid) begin
                    data_q <= data_d;
                    sel_q  <= src_sel;
                end
            end
        end

        assign ready[i] = !valid_q || ready[i+1];

`ifdef MUX_SEL_ERR_EN
        logic src_err;
        logic err_q;

        // The out-of-range flag is computed once at entry and carried with the word.
        if (i == 0) begin : g_err_src
            assign src_err = (SELX_W'(sel) >= SELX_W'(N_IN));
        end else begin : g_err_src
            assign src_err = g_lvl[i-1].err_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                err_q <= 1'b0;
            end else if (ready[i] && src_valid) begin
                err_q <= src_err;
            end
        end
`endif
    end

    assign out       = g_lvl[LEVELS-1].data_q;
    assign out_sel   = g_lvl[LEVELS-1].sel_q;
    assign out_valid = g_lvl[LEVELS-1].valid_q;

`ifdef MUX_SEL_ERR_EN
    assign sel_err   = g_lvl[LEVELS-1].err_q;
`endif

endmodule
